// File: rtl/eth_verdict_pkg.sv
// eth_verdict_pkg: state encoding, tuser port-byte positions and header constants
// shared by the eth_verdict stage and its sub-modules.
package eth_verdict_pkg;
  typedef enum logic [1:0] {ST_WAIT, ST_SEND_IP, ST_SEND_CPU, ST_DROP} state_e;
  localparam int SRC_PORT_POS_DEF = 16;
  localparam int DST_PORT_POS_DEF = 24;
  localparam logic [7:0] NF_PORT_MASK = 8'h55;
  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP = 16'h0806;
  // NF ports sit on even one-hot bits; the matching CPU queue is the next bit up
  function automatic logic [7:0] cpu_port(input logic [7:0] sport);
    return (sport & NF_PORT_MASK) << 1;
  endfunction
endpackage

// File: rtl/eth_verdict_tuser_rewrite.sv
// eth_verdict_tuser_rewrite: when en is set, replaces the destination-port byte of
// tuser with the CPU queue paired with the word's own source port.
module eth_verdict_tuser_rewrite
  import eth_verdict_pkg::*;
#(
  parameter int TUSER_W = 128,
  parameter int SRC_POS = SRC_PORT_POS_DEF,
  parameter int DST_POS = DST_PORT_POS_DEF
) (
  input  logic               en,
  input  logic [TUSER_W-1:0] tuser_in,
  output logic [TUSER_W-1:0] tuser_out
);
  always_comb begin
    tuser_out = tuser_in;
    if (en) tuser_out[DST_POS +: 8] = cpu_port(tuser_in[SRC_POS +: 8]);
  end
endmodule

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO; dout shows the head
// whenever empty is low, rd_en pops it.
module fallthrough_small_fifo #(
  parameter int WIDTH = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0] count_q, count_d;
  logic wr, rd;
  always_comb begin
    wr = wr_en && count_q != (MAX_DEPTH_BITS+1)'(DEPTH);
    rd = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(wr);
    rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(rd);
    count_d = count_q + (MAX_DEPTH_BITS+1)'(wr) - (MAX_DEPTH_BITS+1)'(rd);
  end
  assign empty = count_q == '0;
  assign nearly_full = count_q >= (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  assign dout = mem_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    wr_ptr_q <= rst ? '0 : wr_ptr_d;
    rd_ptr_q <= rst ? '0 : rd_ptr_d;
    count_q <= rst ? '0 : count_d;
  end
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= din;
endmodule

// File: rtl/eth_verdict.sv
// eth_verdict: pairs buffered packets with parser results and drops, punts to CPU or passes
// each one. Define ETH_VERDICT_STATS_EN to add saturating drop/CPU packet counters.
module eth_verdict
  import eth_verdict_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DATA_FIFO_DEPTH_BITS = 3,
  parameter int SRC_PORT_POS = SRC_PORT_POS_DEF,
  parameter int DST_PORT_POS = DST_PORT_POS_DEF
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic                              i_eth_valid,
  input  logic                              i_is_for_us,
  input  logic                              i_is_bmcast,
  input  logic                              i_is_ipv4,
  output logic                              o_rd_eth,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
`ifdef ETH_VERDICT_STATS_EN
  ,
  output logic [31:0]                       o_drop_cnt,
  output logic [31:0]                       o_cpu_cnt
`endif
);
  localparam int KEEP_W = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int FIFO_W = C_S_AXIS_TDATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
  state_e state_q, state_d, verdict;
  logic [FIFO_W-1:0] fifo_dout;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user;
  logic data_empty, nearly_full, fifo_rd, take, out_valid;
  fallthrough_small_fifo #(.WIDTH(FIFO_W), .MAX_DEPTH_BITS(DATA_FIFO_DEPTH_BITS)) data_fifo (
    .clk(axi_aclk),
    .rst(!axi_resetn),
    .din({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
    .wr_en(s_axis_tvalid && s_axis_tready),
    .rd_en(fifo_rd),
    .dout(fifo_dout),
    .nearly_full(nearly_full),
    .empty(data_empty)
  );
  assign {m_axis_tdata, m_axis_tkeep, head_user, m_axis_tlast} = fifo_dout;
  eth_verdict_tuser_rewrite #(
    .TUSER_W(C_S_AXIS_TUSER_WIDTH), .SRC_POS(SRC_PORT_POS), .DST_POS(DST_PORT_POS)
  ) tuser_rewrite (
    .en(state_q == ST_SEND_CPU),
    .tuser_in(head_user),
    .tuser_out(m_axis_tuser)
  );
  // A verdict is only consumed once its packet's first word is buffered, keeping pairing in order
  always_comb begin
    verdict = !i_is_for_us ? ST_DROP : (i_is_bmcast || !i_is_ipv4) ? ST_SEND_CPU : ST_SEND_IP;
    take = state_q == ST_WAIT && !data_empty && i_eth_valid;
    out_valid = (state_q == ST_SEND_IP || state_q == ST_SEND_CPU) && !data_empty;
    fifo_rd = out_valid ? m_axis_tready : state_q == ST_DROP && !data_empty;
    state_d = take ? verdict : (fifo_rd && m_axis_tlast) ? ST_WAIT : state_q;
  end
  assign o_rd_eth = take && axi_resetn;
  assign m_axis_tvalid = out_valid && axi_resetn;
  assign s_axis_tready = !nearly_full && axi_resetn;
  always_ff @(posedge axi_aclk) state_q <= !axi_resetn ? ST_WAIT : state_d;
`ifdef ETH_VERDICT_STATS_EN
  logic [31:0] drop_cnt_q, drop_cnt_d, cpu_cnt_q, cpu_cnt_d;
  always_comb begin
    drop_cnt_d = drop_cnt_q + 32'(take && verdict == ST_DROP && drop_cnt_q != '1);
    cpu_cnt_d = cpu_cnt_q + 32'(take && verdict == ST_SEND_CPU && cpu_cnt_q != '1);
  end
  always_ff @(posedge axi_aclk) begin
    drop_cnt_q <= !axi_resetn ? '0 : drop_cnt_d;
    cpu_cnt_q <= !axi_resetn ? '0 : cpu_cnt_d;
  end
  assign o_drop_cnt = drop_cnt_q;
  assign o_cpu_cnt = cpu_cnt_q;
`endif
endmodule

// File: tb/tb_eth_verdict.sv
// tb_eth_verdict: scoreboard bench for eth_verdict; a packet-level model predicts the
// output words, a parser-FIFO model supplies verdicts, and a monitor checks every output.
`timescale 1ns/1ps
module tb_eth_verdict;
  localparam int DW = 256, KW = 32, UW = 128, SP = 16, DP = 24;
  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l;} word_t;
  typedef struct packed {logic f; logic b; logic i;} vd_t;
  logic axi_aclk = 0, axi_resetn = 0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
  logic i_eth_valid = 0, i_is_for_us = 0, i_is_bmcast = 0, i_is_ipv4 = 0, o_rd_eth;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready = 0;
`ifdef ETH_VERDICT_STATS_EN
  logic [31:0] o_drop_cnt, o_cpu_cnt;
`endif
  int compared = 0, mismatched = 0, cyc = 0, bp = 1, exp_drop = 0, exp_cpu = 0;
  bit hold = 0;
  word_t exp_q[$];
  vd_t vq[$], pend[$];
  int rd_log[$], out_log[$];

  always #5 axi_aclk = ~axi_aclk;

  eth_verdict dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .i_eth_valid(i_eth_valid), .i_is_for_us(i_is_for_us), .i_is_bmcast(i_is_bmcast),
    .i_is_ipv4(i_is_ipv4), .o_rd_eth(o_rd_eth),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
`ifdef ETH_VERDICT_STATS_EN
    , .o_drop_cnt(o_drop_cnt), .o_cpu_cnt(o_cpu_cnt)
`endif
  );

  function automatic void refresh();
    i_eth_valid = vq.size() > 0;
    i_is_for_us = vq.size() > 0 && vq[0].f;
    i_is_bmcast = vq.size() > 0 && vq[0].b;
    i_is_ipv4 = vq.size() > 0 && vq[0].i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Parser result FIFO: one entry leaves per cycle that o_rd_eth is seen
  initial forever begin : parser
    bit r;
    @(negedge axi_aclk);
    r = o_rd_eth;
    @(posedge axi_aclk);
    #1;
    if (r && vq.size() > 0) begin
      void'(vq.pop_front());
      refresh();
    end
  end

  initial forever begin : sink
    @(posedge axi_aclk);
    #1;
    m_axis_tready = bp == 2 ? 1'b0 : bp == 1 ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  initial forever begin : mon
    word_t got, prev, e;
    bit stall;
    @(negedge axi_aclk);
    cyc++;
    got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
    if (!axi_resetn) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", m_axis_tvalid, 1);
        compared++;
        if (got !== prev) begin
          mismatched++;
          $display("FAIL hold_data: got %h expected %h", got, prev);
        end
      end
      if (o_rd_eth) rd_log.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) begin
        out_log.push_back(cyc);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL out_word: got %h expected no word", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL out_word: got %h expected %h", got, e);
          end
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      prev = got;
    end
  end

  task automatic send_word(input word_t w);
    bit r;
    int n = 0;
    {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = w;
    s_axis_tvalid = 1;
    do begin
      @(negedge axi_aclk);
      r = s_axis_tready;
      @(posedge axi_aclk);
      #1;
      n++;
    end while (!r && n < 500);
    if (!r) begin
      compared++;
      mismatched++;
      $display("FAIL in_accept: s_axis_tready low for %0d cycles, required high", n);
    end
    s_axis_tvalid = 0;
  endtask

  task automatic push_verdict(input vd_t v);
    if (hold) pend.push_back(v);
    else begin
      vq.push_back(v);
      refresh();
    end
  endtask

  // Model: drop if not for us, punt if bmcast or non-IPv4, else pass unchanged
  task automatic send_packet(input int len, input bit f, input bit b, input bit i,
                             input logic [7:0] sport, input bit vfirst, input int nsend);
    word_t w;
    word_t pk[$];
    bit drop = !f;
    bit cpu = f && (b || !i);
    for (int n = 0; n < len; n++) begin
      for (int j = 0; j < DW / 32; j++) w.d[j*32 +: 32] = $urandom;
      w.k = $urandom;
      for (int j = 0; j < UW / 32; j++) w.u[j*32 +: 32] = $urandom;
      w.u[SP +: 8] = sport;
      w.l = n == len - 1;
      pk.push_back(w);
      if (!drop) begin
        if (cpu) w.u[DP +: 8] = (sport & 8'h55) * 8'd2;
        exp_q.push_back(w);
      end
    end
    if (drop) exp_drop++;
    if (cpu) exp_cpu++;
    if (vfirst) push_verdict({f, b, i});
    for (int n = 0; n < nsend; n++) send_word(pk[n]);
    if (!vfirst) push_verdict({f, b, i});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || vq.size() > 0) && n < 2000) begin
      @(posedge axi_aclk);
      n++;
    end
    repeat (8) @(posedge axi_aclk);
    #1;
    chk("drain_words", exp_q.size(), 0);
    chk("drain_verdicts", vq.size(), 0);
  endtask

  initial begin
    int len;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_rd_eth", o_rd_eth, 0);
    chk("reset_tready", s_axis_tready, 0);
    @(posedge axi_aclk);
    #1;
    axi_resetn = 1;
    send_packet(3, 1, 0, 1, 8'h01, 1, 3);
    drain();
    send_packet(2, 1, 1, 0, 8'h10, 1, 2);
    drain();
`ifdef ETH_VERDICT_STATS_EN
    chk("cpu_cnt_arp", o_cpu_cnt, 1);
`endif
    send_packet(4, 0, 0, 1, 8'h40, 0, 4);
    drain();
`ifdef ETH_VERDICT_STATS_EN
    chk("drop_cnt_unicast", o_drop_cnt, 1);
`endif
    hold = 1;
    send_packet(1, 0, 0, 1, 8'h07, 1, 1);
    send_packet(2, 1, 0, 1, 8'h02, 1, 2);
    repeat (3) @(posedge axi_aclk);
    #1;
    rd_log.delete();
    out_log.delete();
    hold = 0;
    foreach (pend[n]) vq.push_back(pend[n]);
    pend.delete();
    refresh();
    repeat (10) @(posedge axi_aclk);
    #1;
    chk("b2b_rd_count", rd_log.size(), 2);
    chk("b2b_out_count", out_log.size(), 2);
    if (rd_log.size() == 2 && out_log.size() == 2) begin
      chk("b2b_bubble", rd_log[1] - rd_log[0], 2);
      chk("b2b_latency", out_log[0] - rd_log[1], 1);
      chk("b2b_out_gap", out_log[1] - out_log[0], 1);
    end
    fork
      send_packet(12, 1, 0, 1, 8'h03, 1, 12);
      begin
        repeat (3) @(posedge axi_aclk);
        #1;
        bp = 2;
        repeat (10) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("bp_tready_low", s_axis_tready, 0);
        @(posedge axi_aclk);
        #1;
        bp = 1;
      end
    join
    drain();
    send_packet(6, 1, 1, 1, 8'h09, 1, 3);
    @(posedge axi_aclk);
    #1;
    axi_resetn = 0;
    exp_q.delete();
    vq.delete();
    refresh();
    exp_drop = 0;
    exp_cpu = 0;
    @(negedge axi_aclk);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_rd_eth", o_rd_eth, 0);
    chk("midrst_tready", s_axis_tready, 0);
    @(posedge axi_aclk);
    #1;
    axi_resetn = 1;
`ifdef ETH_VERDICT_STATS_EN
    @(negedge axi_aclk);
    chk("midrst_cpu_cnt", o_cpu_cnt, 0);
`endif
    send_packet(2, 1, 0, 1, 8'h0A, 0, 2);
    drain();
    bp = 0;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 5);
      send_packet(len, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 1)), len);
    end
    bp = 1;
    drain();
`ifdef ETH_VERDICT_STATS_EN
    chk("final_drop_cnt", o_drop_cnt, exp_drop);
    chk("final_cpu_cnt", o_cpu_cnt, exp_cpu);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/eth_verdict.md
Name: eth_verdict

Overview:
- Sits directly downstream of the Ethernet header parser in the router output-port-lookup pipeline.
- Buffers incoming AXI-Stream packet words and pops the parser's per-packet result FIFO (for_us, bmcast, ipv4).
- Applies one verdict per packet: drop, punt to the CPU port, or pass on to the IPv4 stage.
- Drives the parser's read strobe and emits a cleaned AXI-Stream with the destination-port field rewritten when punting.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 256, stream data width.
- C_S_AXIS_TUSER_WIDTH, 128, stream sideband width.
- DATA_FIFO_DEPTH_BITS, 3, log2 depth of the internal packet-word FIFO.
- SRC_PORT_POS, 16, LSB of the source-port byte in tuser.
- DST_PORT_POS, 24, LSB of the destination-port byte in tuser.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  synchronous reset, active-low.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  input packet data.
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input sideband.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tlast  in  1  last word of packet.
- s_axis_tready  out  1  = !data_fifo_nearly_full.
- i_eth_valid  in  1  parser result FIFO non-empty.
- i_is_for_us  in  1  parser result: dmac matches port MAC or is bmcast.
- i_is_bmcast  in  1  parser result: broadcast/multicast.
- i_is_ipv4  in  1  parser result: ethertype 0x0800.
- o_rd_eth  out  1  one-cycle pop of the parser result FIFO.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser / m_axis_tlast / m_axis_tvalid  out  as s_*  output stream.
- m_axis_tready  in  1  downstream ready.
- o_drop_cnt  out  32  present only with ETH_VERDICT_STATS_EN.
- o_cpu_cnt  out  32  present only with ETH_VERDICT_STATS_EN.

Behaviour:
- Clock and reset: single clock axi_aclk; axi_resetn is synchronous, active-low.
- Reset values: m_axis_tvalid=0, o_rd_eth=0, s_axis_tready=0 during reset, state=WAIT, data FIFO flushed, counters=0.
- Reset mid-packet discards all buffered words. The parser is reset in the same cycle.
- Input: a word is accepted when s_axis_tvalid && s_axis_tready. Words are written unmodified into a fallthrough_small_fifo of width tdata+tkeep+tuser+1.
- WAIT state:
  - If data FIFO is non-empty and i_eth_valid: pulse o_rd_eth for exactly one cycle and latch the verdict.
  - Next state is DROP if !i_is_for_us.
  - Otherwise next state is SEND_CPU if i_is_bmcast || !i_is_ipv4.
  - Otherwise next state is SEND_IP.
  - If either FIFO is empty, stay in WAIT and do not pop.
- SEND_IP:
  - m_axis_tvalid = !data_empty; data, keep, user and last come from the FIFO head unchanged.
  - Pop on tvalid && tready.
  - Popping a word with tlast set returns to WAIT.
- SEND_CPU: same as SEND_IP, except every word's tuser[DST_PORT_POS+7:DST_PORT_POS] = (sport & 8'h55) << 1, where sport is taken from that word's tuser[SRC_PORT_POS+7:SRC_PORT_POS]. Example: sport 0x04 gives dst 0x08.
- DROP: m_axis_tvalid=0. Pop one word per cycle while non-empty. Popping tlast returns to WAIT.
- Latency: the first output word may be valid one cycle after the o_rd_eth pulse.
- Back-to-back packets: the cycle that pops tlast always goes to WAIT. Exactly one bubble cycle between packets is permitted and required. The next verdict is taken in that WAIT cycle.
- m_axis_tvalid never drops while m_axis_tready=0 and the FIFO head is present. Output data is held stable under backpressure.
- Single-word packets (tlast on the first word) follow the same flow.
- A verdict present while the data FIFO is empty causes no pop.
- Data FIFO full: s_axis_tready deasserts at nearly_full. No word is ever lost or duplicated.
- Verdict ordering: verdicts pair with packets strictly in FIFO order.

Optional Feature:
- ETH_VERDICT_STATS_EN defined:
  - Adds o_drop_cnt and o_cpu_cnt, 32-bit.
  - o_drop_cnt increments on entry to DROP; o_cpu_cnt increments on entry to SEND_CPU.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (WAIT, SEND_IP, SEND_CPU, DROP), SRC/DST port byte positions, the 8'h55 NF-port mask, ETHTYPE constants.
- The data FIFO reuses fallthrough_small_fifo.
- One natural sub-module: eth_verdict_tuser_rewrite, the combinational dst-port rewrite.

Test Plan:
- IPv4 unicast to us, 3 words, sport 0x01, result {for_us=1, bmcast=0, ipv4=1} -> 3 words out unchanged, dst byte unchanged, one o_rd_eth pulse.
- Broadcast ARP, 2 words, sport 0x10, result {1,1,0} -> 2 words out with tuser[31:24]=0x20; o_cpu_cnt=1 with STATS_EN.
- Unicast not for us, 4 words, sport 0x40, result {0,0,1} -> no m_axis_tvalid, FIFO drained in 4 cycles; o_drop_cnt=1 with STATS_EN.
- Back-to-back: 1-word drop then 2-word IPv4 pass -> exactly one bubble cycle, correct verdict pairing, 2 words out.
- m_axis_tready held low for 10 cycles mid-packet with continuous input -> s_axis_tready falls at nearly_full, no loss, output data stable.
- axi_resetn=0 for 1 cycle mid-packet -> all outputs 0; a new packet after reset passes correctly.
